// File: rtl/mci_pkg.sv
// mci_pkg: shared state, opcode and mux-select encodings for the multicycle control FSM
package mci_pkg;
  typedef logic [3:0] state_t;
  localparam state_t IDLE      = 4'd0;
  localparam state_t FETCH     = 4'd1;
  localparam state_t DECODE    = 4'd2;
  localparam state_t MEM_ADDR  = 4'd3;
  localparam state_t MEM_READ  = 4'd4;
  localparam state_t MEM_WB    = 4'd5;
  localparam state_t MEM_WRITE = 4'd6;
  localparam state_t EXECUTE   = 4'd7;
  localparam state_t ALU_WB    = 4'd8;
  localparam state_t BRANCH    = 4'd9;
  localparam state_t JUMP      = 4'd10;
  localparam logic [5:0] OP_RTYPE  = 6'h00;
  localparam logic [5:0] OP_LW     = 6'h23;
  localparam logic [5:0] OP_SW     = 6'h2B;
  localparam logic [5:0] OP_BEQ    = 6'h04;
  localparam logic [5:0] OP_J      = 6'h02;
  localparam logic [5:0] FUNCT_ADD = 6'h20;
  localparam logic [5:0] ALU_ADD   = 6'h00;
  localparam logic [1:0] PCS_ALU    = 2'd0;
  localparam logic [1:0] PCS_ALUOUT = 2'd1;
  localparam logic [1:0] PCS_JUMP   = 2'd2;
  localparam logic [1:0] ALUB_REG    = 2'd0;
  localparam logic [1:0] ALUB_FOUR   = 2'd1;
  localparam logic [1:0] ALUB_IMM    = 2'd2;
  localparam logic [1:0] ALUB_IMM_SH = 2'd3;
endpackage

// File: rtl/mci_ctrl_decode.sv
// mci_ctrl_decode: maps the FSM state (and mem_ready in FETCH) to datapath control strobes
module mci_ctrl_decode
  import mci_pkg::*;
(
  input  state_t     state,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_read,
  output logic       mem_write,
  output logic       iord,
  output logic       ir_write,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic [1:0] pc_source,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [5:0] alu_op
);
  logic fetch_done;
  assign fetch_done    = state == FETCH && mem_ready;
  assign mem_req       = state == FETCH || state == MEM_READ || state == MEM_WRITE;
  assign mem_read      = state == FETCH || state == MEM_READ;
  assign mem_write     = state == MEM_WRITE;
  assign iord          = state == MEM_READ || state == MEM_WRITE;
  assign ir_write      = fetch_done;
  assign pc_write      = fetch_done || state == JUMP;
  assign pc_write_cond = state == BRANCH;
  assign pc_source     = state == JUMP ? PCS_JUMP : state == BRANCH ? PCS_ALUOUT : PCS_ALU;
  assign reg_write     = state == MEM_WB || state == ALU_WB;
  assign reg_dst       = state == ALU_WB;
  assign mem_to_reg    = state == MEM_WB;
  assign alu_src_a     = state == MEM_ADDR || state == EXECUTE || state == BRANCH;
  assign alu_src_b     = state == FETCH ? ALUB_FOUR : state == DECODE ? ALUB_IMM_SH :
                         state == MEM_ADDR ? ALUB_IMM : ALUB_REG;
  assign alu_op        = ALU_ADD;
endmodule

// File: rtl/mci_control_fsm.sv
// mci_control_fsm: multicycle MIPS-subset control unit with sticky illegal flag and retire counter
module mci_control_fsm
  import mci_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_read,
  output logic             mem_write,
  output logic             iord,
  output logic             ir_write,
  output logic             pc_write,
  output logic             pc_write_cond,
  output logic [1:0]       pc_source,
  output logic             reg_write,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [5:0]       alu_op,
  output logic             illegal,
  output logic [CNT_W-1:0] instr_count
);
  state_t state, nxt;
  logic legal, retire, unused_zero;
  // the branch decision is made by the datapath through pc_write_cond
  assign unused_zero = zero;
  assign legal = opcode == OP_LW || opcode == OP_SW || opcode == OP_BEQ || opcode == OP_J ||
                 (opcode == OP_RTYPE && funct == FUNCT_ADD);
  assign retire = state == MEM_WB || state == ALU_WB || state == BRANCH || state == JUMP ||
                  (state == MEM_WRITE && mem_ready);
  always_comb begin
    nxt = IDLE;
    case (state)
      IDLE:      nxt = FETCH;
      FETCH:     nxt = mem_ready ? DECODE : FETCH;
      DECODE:    nxt = !legal ? FETCH : (opcode == OP_LW || opcode == OP_SW) ? MEM_ADDR :
                       opcode == OP_RTYPE ? EXECUTE : opcode == OP_BEQ ? BRANCH : JUMP;
      MEM_ADDR:  nxt = opcode == OP_SW ? MEM_WRITE : MEM_READ;
      MEM_READ:  nxt = mem_ready ? MEM_WB : MEM_READ;
      MEM_WRITE: nxt = mem_ready ? FETCH : MEM_WRITE;
      EXECUTE:   nxt = ALU_WB;
      MEM_WB, ALU_WB, BRANCH, JUMP: nxt = FETCH;
      default:   nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      illegal     <= 1'b0;
      instr_count <= '0;
    end else begin
      state <= nxt;
      if (state == DECODE && !legal) illegal <= 1'b1;
      if (retire) instr_count <= instr_count + CNT_W'(1);
    end
  end
  mci_ctrl_decode u_dec (
    .state(state), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_read(mem_read), .mem_write(mem_write), .iord(iord),
    .ir_write(ir_write), .pc_write(pc_write), .pc_write_cond(pc_write_cond),
    .pc_source(pc_source), .reg_write(reg_write), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op)
  );
endmodule

// File: tb/tb_mci_control_fsm.sv
// tb_mci_control_fsm: directed scoreboard bench; a spec-level model predicts state, strobes, flag and count
module tb_mci_control_fsm;
  import mci_pkg::*;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [5:0] opcode = '0, funct = '0;
  logic zero = 1'b0, mem_ready = 1'b1;
  logic mem_req, mem_read, mem_write, iord, ir_write, pc_write, pc_write_cond;
  logic reg_write, reg_dst, mem_to_reg, alu_src_a, illegal;
  logic [1:0] pc_source, alu_src_b;
  logic [5:0] alu_op;
  logic [3:0] instr_count;
  mci_control_fsm #(.CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zero(zero), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_read(mem_read), .mem_write(mem_write), .iord(iord),
    .ir_write(ir_write), .pc_write(pc_write), .pc_write_cond(pc_write_cond),
    .pc_source(pc_source), .reg_write(reg_write), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .illegal(illegal), .instr_count(instr_count)
  );
  always #5 clk = ~clk;
  logic [29:0] q[$];
  int errors = 0, checks = 0;
  state_t ms = IDLE;
  logic mill = 1'b0;
  logic [3:0] mcnt = '0;
  // {mem_req,mem_read,mem_write,iord,ir_write,pc_write,pc_write_cond}, pc_source,
  // {reg_write,reg_dst,mem_to_reg,alu_src_a}, alu_src_b, alu_op
  function automatic logic [20:0] exp_ctrl(state_t s, logic mr);
    case (s)
      FETCH:     return {4'b1100, mr, mr, 1'b0, 2'd0, 4'b0000, 2'd1, 6'd0};
      DECODE:    return {7'b0000000, 2'd0, 4'b0000, 2'd3, 6'd0};
      MEM_ADDR:  return {7'b0000000, 2'd0, 4'b0001, 2'd2, 6'd0};
      MEM_READ:  return {7'b1101000, 2'd0, 4'b0000, 2'd0, 6'd0};
      MEM_WB:    return {7'b0000000, 2'd0, 4'b1010, 2'd0, 6'd0};
      MEM_WRITE: return {7'b1011000, 2'd0, 4'b0000, 2'd0, 6'd0};
      EXECUTE:   return {7'b0000000, 2'd0, 4'b0001, 2'd0, 6'd0};
      ALU_WB:    return {7'b0000000, 2'd0, 4'b1100, 2'd0, 6'd0};
      BRANCH:    return {7'b0000001, 2'd1, 4'b0001, 2'd0, 6'd0};
      JUMP:      return {7'b0000010, 2'd2, 4'b0000, 2'd0, 6'd0};
      default:   return '0;
    endcase
  endfunction
  function automatic logic [29:0] observed();
    return {dut.state, mem_req, mem_read, mem_write, iord, ir_write, pc_write, pc_write_cond,
            pc_source, reg_write, reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op,
            illegal, instr_count};
  endfunction
  task automatic compare(input string tag, input logic [29:0] obs);
    logic [29:0] e;
    e = q.pop_front();
    checks++;
    assert (obs === e) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, e);
    end
  endtask
  task automatic expect_eq(input string tag, input logic [29:0] obs, input logic [29:0] e);
    q.push_back(e);
    compare(tag, obs);
  endtask
  task automatic step(input string tag, input logic [5:0] op, input logic [5:0] fn,
                      input logic z, input logic mr);
    state_t n;
    opcode = op; funct = fn; zero = z; mem_ready = mr;
    #1;
    q.push_back({ms, exp_ctrl(ms, mr), mill, mcnt});
    compare(tag, observed());
    n = ms;
    case (ms)
      IDLE:      n = FETCH;
      FETCH:     n = mr ? DECODE : FETCH;
      DECODE: begin
        if (op == 6'h23 || op == 6'h2B) n = MEM_ADDR;
        else if (op == 6'h00 && fn == 6'h20) n = EXECUTE;
        else if (op == 6'h04) n = BRANCH;
        else if (op == 6'h02) n = JUMP;
        else begin n = FETCH; mill = 1'b1; end
      end
      MEM_ADDR:  n = op == 6'h2B ? MEM_WRITE : MEM_READ;
      MEM_READ:  n = mr ? MEM_WB : MEM_READ;
      MEM_WRITE: begin n = mr ? FETCH : MEM_WRITE; if (mr) mcnt++; end
      EXECUTE:   n = ALU_WB;
      default:   begin n = FETCH; mcnt++; end
    endcase
    ms = n;
    @(posedge clk); #1;
  endtask
  task automatic run(input string tag, input logic [5:0] op, input logic [5:0] fn, input logic z);
    int k = 0;
    step(tag, op, fn, z, 1'b1);
    while (ms != FETCH && k < 10) begin step(tag, op, fn, z, 1'b1); k++; end
  endtask
  initial begin
    #2;
    q.push_back({IDLE, 21'd0, 1'b0, 4'd0});
    compare("reset", observed());
    @(posedge clk); #1;
    rst_n = 1'b1;
    step("idle", 6'h23, 6'h00, 1'b0, 1'b1);
    run("lw", 6'h23, 6'h00, 1'b0);
    expect_eq("lw_count", {26'd0, instr_count}, 30'd1);
    run("beq_z1", 6'h04, 6'h00, 1'b1);
    run("beq_z0", 6'h04, 6'h00, 1'b0);
    expect_eq("beq_count", {26'd0, instr_count}, 30'd3);
    step("sw", 6'h2B, 6'h00, 1'b0, 1'b1);
    step("sw", 6'h2B, 6'h00, 1'b0, 1'b1);
    step("sw", 6'h2B, 6'h00, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) step("sw_wait", 6'h2B, 6'h00, 1'b0, 1'b0);
    step("sw_done", 6'h2B, 6'h00, 1'b0, 1'b1);
    expect_eq("sw_count", {26'd0, instr_count}, 30'd4);
    step("j_fwait", 6'h02, 6'h00, 1'b0, 1'b0);
    step("j_fwait", 6'h02, 6'h00, 1'b0, 1'b0);
    run("j", 6'h02, 6'h00, 1'b0);
    run("ill_op", 6'h3F, 6'h00, 1'b0);
    run("ill_fn", 6'h00, 6'h22, 1'b0);
    expect_eq("ill_flag", {25'd0, illegal, instr_count}, {25'd0, 1'b1, 4'd5});
    run("add", 6'h00, 6'h20, 1'b0);
    expect_eq("ill_sticky", {25'd0, illegal, instr_count}, {25'd0, 1'b1, 4'd6});
    step("lw_rst", 6'h23, 6'h00, 1'b0, 1'b1);
    step("lw_rst", 6'h23, 6'h00, 1'b0, 1'b1);
    step("lw_rst", 6'h23, 6'h00, 1'b0, 1'b1);
    step("lw_rst_wait", 6'h23, 6'h00, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    ms = IDLE; mill = 1'b0; mcnt = '0;
    expect_eq("async_rst", observed(), {IDLE, 21'd0, 1'b0, 4'd0});
    @(posedge clk); #1;
    expect_eq("rst_hold", observed(), {IDLE, 21'd0, 1'b0, 4'd0});
    rst_n = 1'b1;
    step("post_rst", 6'h00, 6'h20, 1'b0, 1'b1);
    for (int i = 1; i <= 16; i++) begin
      run("wrap_add", 6'h00, 6'h20, 1'b0);
      if (i == 15) expect_eq("cnt15", {26'd0, instr_count}, 30'd15);
    end
    expect_eq("wrap", {26'd0, instr_count}, 30'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
